// File: rtl/bram_port_arb_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bram_port_arb_pkg : shared widths, requester ids and read-tag type
// Revision 1.0
// ---------------------------------------------------------------------------
package bram_port_arb_pkg;

    localparam int BRAM_AW = 8;
    localparam int BRAM_DW = 16;

    localparam logic REQ_ID0 = 1'b0;
    localparam logic REQ_ID1 = 1'b1;

    typedef struct packed {
        logic valid;
        logic id;
    } tag_t;

    localparam tag_t TAG_EMPTY = '{valid: 1'b0, id: REQ_ID0};

endpackage
`default_nettype wire

// File: rtl/bram_port_arb_rr_arb2.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_arb2 : two-way round-robin / fixed-priority grant with last-grant state
// Revision 1.0
// ---------------------------------------------------------------------------
module rr_arb2
    import bram_port_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [1:0] mask,
    input  logic       rr_en,
    output logic [1:0] gnt
);

    logic       r_last_grant;
    logic [1:0] w_elig;

    assign w_elig = req & ~mask;

    always_comb begin
        gnt = 2'b00;
        case (w_elig)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            // Tie: alternate away from the previous winner, or favour requester 0.
            2'b11:   gnt = (rr_en && (r_last_grant == REQ_ID0)) ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= REQ_ID1;
        end else if (|gnt) begin
            r_last_grant <= gnt[1];
        end
    end

endmodule
`default_nettype wire

// File: rtl/bram_port_arb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bram_port_arb : shares one 256x16 block RAM between two single-beat clients
// Revision 1.0
// ---------------------------------------------------------------------------
module bram_port_arb
    import bram_port_arb_pkg::*;
#(
    parameter int AW = BRAM_AW,
    parameter int DW = BRAM_DW,
    parameter int RR = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    input  logic          req0_we,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_wdata,
    output logic          req0_ready,
    output logic          rsp0_valid,
    input  logic          req1_valid,
    input  logic          req1_we,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_wdata,
    output logic          req1_ready,
    output logic          rsp1_valid,
    output logic [DW-1:0] rsp_rdata,
    output logic [AW-1:0] ram_raddr,
    output logic          ram_re,
    output logic [AW-1:0] ram_waddr,
    output logic [DW-1:0] ram_wdata,
    output logic          ram_we,
    output logic [DW-1:0] ram_mask,
    input  logic [DW-1:0] ram_rdata
);

    logic          w_valid [2];
    logic          w_we    [2];
    logic [AW-1:0] w_addr  [2];
    logic [DW-1:0] w_wdata [2];
    logic [1:0]    w_req;
    logic [1:0]    w_mask;
    logic [1:0]    w_gnt;
    logic          w_acc;
    logic          w_sel;
    logic          w_sel_we;
    logic [AW-1:0] w_sel_addr;
    logic [DW-1:0] w_sel_wdata;
    tag_t          r_stage1;
    tag_t          r_stage2;

    assign w_valid[0] = req0_valid;
    assign w_we[0]    = req0_we;
    assign w_addr[0]  = req0_addr;
    assign w_wdata[0] = req0_wdata;
    assign w_valid[1] = req1_valid;
    assign w_we[1]    = req1_we;
    assign w_addr[1]  = req1_addr;
    assign w_wdata[1] = req1_wdata;

    // A read to the address written at the previous edge is held off one cycle
    // so the BRAM sees the write before the read.
    genvar n;
    generate
        for (n = 0; n < 2; n++) begin : g_hazard
            assign w_req[n]  = w_valid[n];
            assign w_mask[n] = ~w_we[n] & ram_we & (w_addr[n] == ram_waddr);
        end
    endgenerate

    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .req   (w_req),
        .mask  (w_mask),
        .rr_en (RR != 0),
        .gnt   (w_gnt)
    );

    assign req0_ready  = w_gnt[0];
    assign req1_ready  = w_gnt[1];
    assign w_acc       = |w_gnt;
    assign w_sel       = w_gnt[1];
    assign w_sel_we    = w_sel ? req1_we    : req0_we;
    assign w_sel_addr  = w_sel ? req1_addr  : req0_addr;
    assign w_sel_wdata = w_sel ? req1_wdata : req0_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_raddr <= '0;
            ram_re    <= 1'b0;
            ram_waddr <= '0;
            ram_wdata <= '0;
            ram_we    <= 1'b0;
            r_stage1  <= TAG_EMPTY;
            r_stage2  <= TAG_EMPTY;
        end else begin
            ram_we <= w_acc & w_sel_we;
            ram_re <= w_acc & ~w_sel_we;
            if (w_acc && w_sel_we) begin
                ram_waddr <= w_sel_addr;
                ram_wdata <= w_sel_wdata;
            end
            if (w_acc && !w_sel_we) begin
                ram_raddr <= w_sel_addr;
            end
            r_stage1 <= '{valid: w_acc & ~w_sel_we, id: w_sel};
            r_stage2 <= r_stage1;
        end
    end

    assign rsp0_valid = r_stage2.valid && (r_stage2.id == REQ_ID0);
    assign rsp1_valid = r_stage2.valid && (r_stage2.id == REQ_ID1);
    assign rsp_rdata  = ram_rdata;
    assign ram_mask   = '0;

endmodule
`default_nettype wire
